// File: rtl/multdiv_pkg.sv
// Shared constants, instruction field positions and FSM encoding for the
// multiply/divide sequencing controller.
package multdiv_pkg;

    localparam logic [4:0] OPC_RTYPE = 5'd0;
    localparam logic [4:0] ALUOP_MUL = 5'd6;
    localparam logic [4:0] ALUOP_DIV = 5'd7;

    // Field positions inside the D/X instruction word
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 27;
    localparam int RD_MSB    = 26;
    localparam int RD_LSB    = 22;
    localparam int ALUOP_MSB = 6;
    localparam int ALUOP_LSB = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/multdiv_iter.sv
// Radix-2 iterative datapath shared by multiply and divide.
// One 2*WIDTH accumulator serves both operations:
//   mult: {partial product high, multiplier shifting out at the bottom}
//   div : {remainder, dividend shifting up / quotient bits shifting in}
// Operands are unsigned magnitudes; sign handling lives in the controller.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic               unused_diff;

    // Shift-add step: conditionally add multiplicand to the high half, then shift right
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};

    // Restoring-division step: shift next dividend bit into remainder, trial-subtract divisor
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = {1'b0, div_sh} - {2'b00, b_q};
    assign div_ok   = ~div_diff[WIDTH+1];
    // On a successful subtract the difference is below the divisor, so bit WIDTH is zero
    assign unused_diff = div_diff[WIDTH];

    // Next-state: load operands, or advance one iteration
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i) begin
            if (div_i) begin
                if (div_ok) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else        acc_d = {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the shared iterative multiply/divide unit.
// Decodes the D/X instruction, stalls the front end while the engine iterates,
// and presents a signed result for one cycle to the X/M latch.
// Optional: MULTDIV_EARLY_OUT_EN finishes trivially-zero results in one cycle.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      DXIR,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             ctrl_stall,
    output logic [WIDTH-1:0] md_result,
    output logic [4:0]       md_rd,
    output logic             md_valid,
    output logic             md_exception,
    output logic             md_busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic [4:0]         rd_q, rd_d;
    logic               force_q, force_d;   // result forced to zero (no iteration)
    logic               fexc_q, fexc_d;     // exception value for forced results

    logic [4:0]         opcode, alu_op, rd;
    logic               is_md, is_div;
    logic               a_neg, b_neg, b_zero, early_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               load, step;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_hi;
    logic [WIDTH-1:0]   quot_s, res_raw;
    logic               ovf, exc_raw;
    logic               unused_ir;

    assign opcode = DXIR[OPC_MSB:OPC_LSB];
    assign rd     = DXIR[RD_MSB:RD_LSB];
    assign alu_op = DXIR[ALUOP_MSB:ALUOP_LSB];
    assign unused_ir = ^{DXIR[RD_LSB-1:ALUOP_MSB+1], DXIR[ALUOP_LSB-1:0]};

    assign is_md  = (opcode == OPC_RTYPE) && ((alu_op == ALUOP_MUL) || (alu_op == ALUOP_DIV));
    assign is_div = is_md && (alu_op == ALUOP_DIV);

    assign a_neg  = operandA[WIDTH-1];
    assign b_neg  = operandB[WIDTH-1];
    assign a_mag  = a_neg ? -operandA : operandA;
    assign b_mag  = b_neg ? -operandB : operandB;
    assign b_zero = (operandB == '0);

`ifdef MULTDIV_EARLY_OUT_EN
    assign early_zero = is_div ? (!b_zero && (a_mag < b_mag))
                               : ((operandA == '0) || b_zero);
`else
    assign early_zero = 1'b0;
`endif

    // Next-state: decode in IDLE, count iterations in RUN, retire in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rd_d    = rd_q;
        force_d = force_q;
        fexc_d  = fexc_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_md) begin
                    div_d   = is_div;
                    neg_d   = a_neg ^ b_neg;
                    rd_d    = rd;
                    cnt_d   = '0;
                    force_d = 1'b0;
                    fexc_d  = 1'b0;
                    if (is_div && b_zero) begin
                        state_d = ST_DONE;
                        force_d = 1'b1;
                        fexc_d  = 1'b1;
                    end else if (early_zero) begin
                        state_d = ST_DONE;
                        force_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        load    = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset discards any in-flight operation
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            force_q <= 1'b0;
            fexc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            force_q <= force_d;
            fexc_q  <= fexc_d;
        end
    end

    multdiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (load),
        .step_i (step),
        .div_i  (div_q),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .acc_o  (acc)
    );

    // Sign correction; overflow when the top WIDTH+1 product bits disagree.
    // Quotient negation truncates toward zero, and MIN/-1 wraps back to MIN.
    assign prod_s  = neg_q ? -acc : acc;
    assign prod_hi = prod_s[2*WIDTH-1:WIDTH-1];
    assign ovf     = !((&prod_hi) || !(|prod_hi));
    assign quot_s  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign res_raw = div_q ? quot_s : prod_s[WIDTH-1:0];
    assign exc_raw = div_q ? 1'b0 : ovf;

    assign md_busy      = (state_q != ST_IDLE);
    assign md_valid     = (state_q == ST_DONE);
    assign md_result    = (md_valid && !force_q) ? res_raw : '0;
    assign md_exception = md_valid && (force_q ? fexc_q : exc_raw);
    assign md_rd        = md_valid ? rd_q : 5'd0;
    assign ctrl_stall   = ((state_q == ST_IDLE) && is_md) || (state_q == ST_RUN);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_multdiv_ctrl;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic [31:0]   DXIR;
    logic [W-1:0]  operandA, operandB;
    logic          ctrl_stall;
    logic [W-1:0]  md_result;
    logic [4:0]    md_rd;
    logic          md_valid, md_exception, md_busy;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;
    int cyc   = 0;

    multdiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .DXIR         (DXIR),
        .operandA     (operandA),
        .operandB     (operandB),
        .ctrl_stall   (ctrl_stall),
        .md_result    (md_result),
        .md_rd        (md_rd),
        .md_valid     (md_valid),
        .md_exception (md_exception),
        .md_busy      (md_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] aop);
        return {opc, rd, 15'd0, aop, 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, latency from the documented rules
    task automatic ref_md(input logic [4:0] aop, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic exc, output int lat);
        longint sa, sb, p, aa, ab;
        bit     trivial;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        aa = (sa < 0) ? -sa : sa;
        ab = (sb < 0) ? -sb : sb;
        lat = W + 1;
        trivial = 1'b0;
        if (aop == 5'd6) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            trivial = (a == 0) || (b == 0);
        end else if (b == 0) begin
            res = '0;
            exc = 1'b1;
            lat = 1;
        end else begin
            p   = sa / sb;
            res = p[31:0];
            exc = 1'b0;
            trivial = (aa < ab);
        end
`ifdef MULTDIV_EARLY_OUT_EN
        if (trivial) lat = 1;
`endif
    endtask

    // Called at a falling edge: puts the op in DX, follows it to retirement,
    // then loads the next DX contents during the retire cycle.
    task automatic run_op(input string tag, input logic [4:0] aop, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] nir, input logic [31:0] na, input logic [31:0] nb,
                          output int vcyc);
        logic [31:0] eres;
        logic        eexc;
        int          elat, lat, bad;
        ref_md(aop, a, b, eres, eexc, elat);
        DXIR = mk(5'd0, rd, aop);
        operandA = a;
        operandB = b;
        #1;
        chk({tag, ":stall_t"}, ctrl_stall, 1);
        lat = 0;
        bad = 0;
        while (lat < 2 * W + 8) begin
            @(negedge clock);
            #1;
            lat++;
            if (md_valid === 1'b1) break;
            if (!(ctrl_stall === 1'b1 && md_busy === 1'b1)) bad++;
            operandA = $urandom;
            operandB = $urandom;
        end
        chk({tag, ":latency"}, lat, elat);
        chk({tag, ":run_stall"}, bad, 0);
        chk({tag, ":result"}, md_result, eres);
        chk({tag, ":exc"}, md_exception, eexc);
        chk({tag, ":rd"}, md_rd, rd);
        chk({tag, ":done_nostall"}, ctrl_stall, 0);
        vcyc = cyc;
        DXIR = nir;
        operandA = na;
        operandB = nb;
    endtask

    logic [31:0] ADD;
    int v1, v2, bad;
    logic [4:0]  raop, rrd;
    logic [31:0] ra, rb;

    initial begin
        ADD = mk(5'd0, 5'd3, 5'd0);
        reset = 1'b1;
        DXIR = ADD;
        operandA = '0;
        operandB = '0;
        #1;
        chk("rst_busy", md_busy, 0);
        chk("rst_valid", md_valid, 0);
        chk("rst_result", md_result, 0);
        chk("rst_rd", md_rd, 0);
        chk("rst_exc", md_exception, 0);
        chk("rst_stall", ctrl_stall, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Non-R-type carrying aluOp 6 is not a multiply
        @(negedge clock);
        DXIR = mk(5'd3, 5'd1, 5'd6);
        operandA = 32'd5;
        operandB = 32'd6;
        #1;
        chk("nonr_stall", ctrl_stall, 0);
        @(negedge clock); #1;
        chk("nonr_busy", md_busy, 0);

        @(negedge clock);
        run_op("mul7x-6", 5'd6, 5'd5, 32'd7, -32'sd6, ADD, 0, 0, v1);
        @(negedge clock);
        run_op("div-100/7", 5'd7, 5'd8, -32'sd100, 32'd7, ADD, 0, 0, v1);
        @(negedge clock);
        run_op("div5/0", 5'd7, 5'd9, 32'd5, 32'd0, ADD, 0, 0, v1);
        @(negedge clock); #1;
        chk("div0_after_stall", ctrl_stall, 0);
        run_op("mulovf", 5'd6, 5'd10, 32'h10000, 32'h10000, ADD, 0, 0, v1);
        @(negedge clock);
        run_op("divmin", 5'd7, 5'd11, 32'h80000000, 32'hFFFFFFFF, ADD, 0, 0, v1);
        @(negedge clock);
        run_op("mulmin", 5'd6, 5'd12, 32'h80000000, 32'hFFFFFFFF, ADD, 0, 0, v1);
        @(negedge clock);
        run_op("mul0x9", 5'd6, 5'd13, 32'd0, 32'd9, ADD, 0, 0, v1);
        @(negedge clock);
        run_op("div3/-10", 5'd7, 5'd14, 32'd3, -32'sd10, ADD, 0, 0, v1);

        // Back-to-back: div sits in DX right behind the mult
        @(negedge clock);
        run_op("b2b_mul", 5'd6, 5'd20, -32'sd1234, 32'd5678,
               mk(5'd0, 5'd21, 5'd7), -32'sd99999, 32'd37, v1);
        @(negedge clock);
        run_op("b2b_div", 5'd7, 5'd21, -32'sd99999, 32'd37, ADD, 0, 0, v2);
        chk("b2b_gap", v2 - v1, W + 2);

        // Asynchronous reset in the middle of an iteration
        @(negedge clock);
        DXIR = mk(5'd0, 5'd9, 5'd6);
        operandA = 32'd123456;
        operandB = -32'sd789;
        repeat (10) @(negedge clock);
        #1;
        chk("midrun_busy", md_busy, 1);
        reset = 1'b1;
        #1;
        chk("mrst_busy", md_busy, 0);
        chk("mrst_valid", md_valid, 0);
        chk("mrst_result", md_result, 0);
        chk("mrst_rd", md_rd, 0);
        chk("mrst_exc", md_exception, 0);
        chk("mrst_stall_md", ctrl_stall, 1);
        DXIR = ADD;
        #1;
        chk("mrst_stall_add", ctrl_stall, 0);
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clock); #1;
            if (ctrl_stall !== 1'b0 || md_valid !== 1'b0 || md_busy !== 1'b0) bad++;
        end
        chk("post_rst_idle", bad, 0);

        // Randomized mix of signs, magnitudes and corner operands
        for (int i = 0; i < 16; i++) begin
            raop = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
            rrd  = 5'($urandom_range(1, 31));
            case ($urandom_range(0, 4))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = 32'($urandom_range(0, 400)) - 32'd200;
                         rb = 32'($urandom_range(0, 400)) - 32'd200; end
                2: begin ra = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
                         rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 1000)); end
                3: begin ra = 32'h80000000;
                         rb = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(1, 70000)); end
                default: begin ra = {{16{1'b0}}, 16'($urandom)} - 32'h8000;
                               rb = {{16{1'b0}}, 16'($urandom)} - 32'h8000; end
            endcase
            @(negedge clock);
            run_op($sformatf("rnd%0d", i), raop, rrd, ra, rb, ADD, 0, 0, v1);
        end

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing controller for the shared iterative multiply/divide unit in the execute stage.
- Decodes the DX-latch instruction. On an R-type (opcode 0) with ALU op 6 (mult) or 7 (div), it latches the operands and drives a radix-2 iterative engine for WIDTH cycles.
- Stalls F/D/X until the result is ready, then presents the result, destination register and exception flag to the X/M latch for one cycle.

Parameters:
- WIDTH, 32, operand/result width; also the iteration count.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- DXIR  in  32  instruction in the D/X latch. opcode=[31:27], rd=[26:22], aluOp=[6:2].
- operandA  in  WIDTH  rs value (bypassed).
- operandB  in  WIDTH  rt value (bypassed).
- ctrl_stall  out  1  freezes PC, F/D and D/X latches; inserts a bubble into X/M.
- md_result  out  WIDTH  product low word or quotient.
- md_rd  out  5  destination register of the completed op.
- md_valid  out  1  one-cycle pulse: md_result/md_rd/md_exception are valid; X/M selects md_result.
- md_exception  out  1  divide-by-zero, or signed product overflow; qualified by md_valid.
- md_busy  out  1  state != IDLE.

Behaviour:
- is_md = (DXIR[31:27]==0) && (DXIR[6:2]==6 || DXIR[6:2]==7). is_div = is_md && op==7.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - If is_md: latch |A|, |B|, result sign, is_div, rd; clear counter; go to RUN.
  - Exception: if is_div && operandB==0, go to DONE with result 0 and exception 1.
  - If not is_md: stay in IDLE.
- RUN:
  - One iteration per cycle; counter increments.
  - After WIDTH iterations (counter==WIDTH-1), go to DONE.
  - mult: shift-add on magnitudes, 2*WIDTH-bit accumulator.
  - div: restoring division on magnitudes, WIDTH-bit remainder.
- DONE:
  - md_valid=1; md_result applies sign correction (negate if signs differ; quotient truncates toward zero).
  - md_rd = latched rd.
  - Go to IDLE unconditionally.
- ctrl_stall = (state==IDLE && is_md) || state==RUN. It is deasserted in DONE so the instruction retires into X/M that cycle.
- Latency: instruction is in DX at cycle t. md_valid is at cycle t+WIDTH+1 (RUN cycles t+1..t+WIDTH, DONE at t+WIDTH+1). The divide-by-zero path gives md_valid at t+1.
- Back-to-back mult/div: the DONE cycle ignores DXIR (old instruction still present). The next instruction is evaluated in the following IDLE cycle, with no lost cycle beyond that.
- Mult overflow: md_exception=1 when the signed 2*WIDTH-bit product is not representable in WIDTH bits (upper WIDTH+1 bits not all equal to the result sign). md_result is still the low word.
- Div special case: most-negative / -1 gives result = most-negative, exception=0 (wraps).
- Operands are sampled only at the IDLE→RUN transition. DXIR/operand changes during RUN are ignored.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, counter=0, all registered outputs 0 (md_result, md_rd, md_valid, md_exception, md_busy).
  - The in-flight op is discarded.
  - ctrl_stall follows the combinational rule, so it is 1 immediately if DXIR is mult/div.

Optional Feature:
- MULTDIV_EARLY_OUT_EN defined: in IDLE, if is_md and either operand is 0 (mult), or |A| < |B| (div, B≠0), go directly to DONE. The result is 0, except div with |A|<|B| gives quotient 0; exception 0. Latency is 1 cycle.
- Undefined: these cases take the full WIDTH iterations, with identical results.

Decomposition:
- Shared package multdiv_pkg:
  - OPC_RTYPE=5'd0, ALUOP_MUL=5'd6, ALUOP_DIV=5'd7.
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Field position constants for opcode/rd/aluOp.
- One sub-module multdiv_iter:
  - Pure iterative datapath (accumulator/remainder registers, one step per `step` pulse, load on `load`).
  - multdiv_ctrl holds the FSM, counter, decode, sign/exception logic and stall.

Test Plan:
- mult 7 × -6 (DXIR op 6, rd=5) → ctrl_stall high for cycles t..t+32; md_valid at t+33 with md_result=0xFFFFFFD6, md_rd=5, md_exception=0.
- div -100 / 7 → md_result=0xFFFFFFF2 (-14), md_exception=0, md_valid after 33 cycles.
- div 5 / 0 → md_valid at t+1, md_result=0, md_exception=1, ctrl_stall high only at cycle t.
- mult 0x10000 × 0x10000 → md_result=0, md_exception=1 (overflow); 0x80000000 / 0xFFFFFFFF → md_result=0x80000000, md_exception=0.
- Assert reset at RUN iteration 10 → all outputs 0, md_busy=0 immediately. After release with an add in DXIR: no stall, no md_valid.
- Back-to-back mult then div in consecutive DX slots → two md_valid pulses separated by exactly 34 cycles, correct rd for each. With MULTDIV_EARLY_OUT_EN, mult 0 × 9 → md_valid at t+1.
